fifo_sync_param: RTL and testbench

//  Parametrised single-clock synchronous FIFO; next generation of the 6-bit/8-deep datapath FIFO.

---
 rtl/fifo_sync_param.sv | 125 ++++++++++++
 tb/tb_fifo_sync_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock synchronous FIFO with occupancy
//               count, almost-full/almost-empty thresholds and sticky
//               overflow/underflow flags.
//               Optional macro FIFO_FWFT_EN selects first-word-fall-through
//               read mode; undefined gives registered read with latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
    parameter int DATA_WIDTH      = 6,
    parameter int DEPTH           = 8,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    fifo_wr,
    input  logic                    fifo_rd,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_full,
    output logic                    err_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF_TH = c_CW'(ALMOST_FULL_TH);
    localparam logic [c_CW-1:0] c_AE_TH = c_CW'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_err_full;
    logic                  r_err_empty;

    logic                  w_rd_acc;
    logic                  w_wr_acc;

    // Flags decode the registered count only, so no input reaches a flag.
    assign fifo_empty   = (r_count == '0);
    assign fifo_full    = (r_count == c_DEPTH);
    assign almost_empty = (r_count <= c_AE_TH);
    assign almost_full  = (r_count >= c_AF_TH);
    assign count        = r_count;
    assign err_full     = r_err_full;
    assign err_empty    = r_err_empty;

    // A read frees a slot in the same cycle, so a full FIFO can still
    // accept a write when it is also being read.
    assign w_rd_acc = fifo_rd && !fifo_empty;
    assign w_wr_acc = fifo_wr && (!fifo_full || w_rd_acc);

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy count and sticky error flags.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err_full  <= 1'b0;
            r_err_empty <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
            if (fifo_wr && !w_wr_acc) begin
                r_err_full <= 1'b1;
            end
            if (fifo_rd && fifo_empty) begin
                r_err_empty <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown directly; fifo_rd acknowledges and pops it.
    assign data_out  = fifo_empty ? '0 : r_mem[r_rd_ptr];
    assign valid_out = !fifo_empty;
`else
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;

    // Registered read: word appears one edge after the accepted read.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Self-checking bench for fifo_sync_param using a queue-based
//               reference model; honours FIFO_FWFT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

    localparam int c_DEPTH = 8;
    localparam int c_AF    = 6;
    localparam int c_AE    = 2;

    logic       clk = 1'b0;
    logic       RESET;
    logic [5:0] data_in;
    logic       fifo_wr;
    logic       fifo_rd;
    logic [5:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_empty;
    logic       almost_full;
    logic [3:0] count;
    logic       err_full;
    logic       err_empty;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [5:0] m_q [$];
    logic [5:0] m_dout;
    logic       m_valid;
    logic       m_err_full;
    logic       m_err_empty;

    fifo_sync_param #(
        .DATA_WIDTH      (6),
        .DEPTH           (c_DEPTH),
        .ALMOST_FULL_TH  (c_AF),
        .ALMOST_EMPTY_TH (c_AE)
    ) u_dut (
        .clk          (clk),
        .RESET        (RESET),
        .data_in      (data_in),
        .fifo_wr      (fifo_wr),
        .fifo_rd      (fifo_rd),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .err_full     (err_full),
        .err_empty    (err_empty)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        check({tag, ".count"},        32'(count),        32'(sz));
        check({tag, ".empty"},        32'(fifo_empty),   32'(sz == 0));
        check({tag, ".full"},         32'(fifo_full),    32'(sz == c_DEPTH));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= c_AE));
        check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= c_AF));
        check({tag, ".err_full"},     32'(err_full),     32'(m_err_full));
        check({tag, ".err_empty"},    32'(err_empty),    32'(m_err_empty));
`ifdef FIFO_FWFT_EN
        check({tag, ".valid"},        32'(valid_out),    32'(sz != 0));
        check({tag, ".data"},         32'(data_out),     (sz != 0) ? 32'(m_q[0]) : 32'd0);
`else
        check({tag, ".valid"},        32'(valid_out),    32'(m_valid));
        check({tag, ".data"},         32'(data_out),     32'(m_dout));
`endif
    endtask

    // One clock: drive inputs, take the edge, advance the model, check.
    task automatic cycle(input string tag, input logic rst, input logic wr,
                         input logic rd, input logic [5:0] din);
        bit rd_ok;
        bit wr_ok;
        RESET   = rst;
        fifo_wr = wr;
        fifo_rd = rd;
        data_in = din;
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_dout      = '0;
            m_valid     = 1'b0;
            m_err_full  = 1'b0;
            m_err_empty = 1'b0;
        end else begin
            rd_ok = rd && (m_q.size() > 0);
            wr_ok = wr && ((m_q.size() < c_DEPTH) || rd_ok);
            if (rd && !rd_ok) m_err_empty = 1'b1;
            if (wr && !wr_ok) m_err_full = 1'b1;
            m_valid = rd_ok;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(din);
        end
        check_all(tag);
    endtask

    initial begin
        RESET   = 1'b1;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        data_in = '0;

        // Reset held two cycles with a write request pending.
        cycle("rst0", 1'b1, 1'b1, 1'b0, 6'h3F);
        cycle("rst1", 1'b1, 1'b1, 1'b0, 6'h3F);
        cycle("idle", 1'b0, 1'b0, 1'b0, 6'h00);

        // Single word round trip.
        cycle("wr12", 1'b0, 1'b1, 1'b0, 6'h12);
        cycle("rd12", 1'b0, 1'b0, 1'b1, 6'h00);
        check("rd12.explicit", 32'(data_out), 32'h12);
        cycle("idle2", 1'b0, 1'b0, 1'b0, 6'h00);

        // Fill to full, then drain in order.
        for (int i = 1; i <= 8; i++) cycle("fill", 1'b0, 1'b1, 1'b0, 6'(i));
        check("fill.full", 32'(fifo_full), 32'd1);
        for (int i = 1; i <= 8; i++) cycle("drain", 1'b0, 1'b0, 1'b1, 6'h00);
        check("drain.empty", 32'(fifo_empty), 32'd1);

        // Overflow: extra write dropped, err_full sticky.
        for (int i = 0; i < 8; i++) cycle("fill2", 1'b0, 1'b1, 1'b0, 6'(8'h30 + i));
        cycle("ovf", 1'b0, 1'b1, 1'b0, 6'h2A);
        check("ovf.err_full", 32'(err_full), 32'd1);
        // Full with simultaneous write and read: both accepted, no new error.
        cycle("full_wr_rd", 1'b0, 1'b1, 1'b1, 6'h15);
        for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, 1'b0, 1'b1, 6'h00);

        // Underflow: read while empty.
        cycle("udf", 1'b0, 1'b0, 1'b1, 6'h00);
        check("udf.valid", 32'(valid_out), 32'd0);
        // Empty with wr+rd: write accepted, read rejected.
        cycle("empty_wr_rd", 1'b0, 1'b1, 1'b1, 6'h0B);
        cycle("rst_err", 1'b1, 1'b0, 1'b0, 6'h00);

        // Stream 20 words across pointer wrap with overlapping wr/rd.
        begin
            int sent = 0;
            while (sent < 20) begin
                logic wr;
                logic rd;
                wr = ($urandom_range(0, 3) != 0);
                rd = (sent > 4) && ($urandom_range(0, 2) != 0);
                cycle("stream", 1'b0, wr, rd, 6'($urandom));
                if (wr && ((m_q.size() > 0) || 1'b1)) sent++;
            end
        end
        for (int i = 0; i < 10; i++) cycle("stream_drain", 1'b0, 1'b0, 1'b1, 6'h00);

        // Random traffic, then reset mid-stream.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'b0, 1'($urandom), 1'($urandom), 6'($urandom));
        end
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b0, 1'b1, 1'b0, 6'($urandom));
        cycle("mid_rst", 1'b1, 1'b1, 1'b1, 6'h11);
        check("mid_rst.count", 32'(count), 32'd0);
        for (int i = 0; i < 100; i++) begin
            cycle("rand2", 1'b0, 1'($urandom), 1'($urandom), 6'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
